// File: rtl/pclk_rate_pkg.sv
// Shared types and constants for the PCLK rate controller: FSM states,
// legal DataBusWidth values and the matching PCLK divide ratios.
package pclk_rate_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_RUN       = 3'd1,
        ST_GATE      = 3'd2,
        ST_DIV_RST   = 3'd3,
        ST_SETTLE    = 3'd4
    } state_t;

    localparam logic [5:0] W8  = 6'd8;
    localparam logic [5:0] W16 = 6'd16;
    localparam logic [5:0] W32 = 6'd32;

    localparam logic [7:0] R10 = 8'd10;
    localparam logic [7:0] R20 = 8'd20;
    localparam logic [7:0] R40 = 8'd40;

    typedef struct packed {
        logic       valid;
        logic [7:0] ratio;
    } ratio_lookup_t;

    // An illegal width reports valid=0 and a harmless default ratio.
    function automatic ratio_lookup_t width_to_ratio(input logic [5:0] width);
        ratio_lookup_t r;
        r.valid = 1'b1;
        r.ratio = R10;
        case (width)
            W8:      r.ratio = R10;
            W16:     r.ratio = R20;
            W32:     r.ratio = R40;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pclk_lock_qual.sv
// PLL lock qualifier: declares lock after LOCK_CYC consecutive cycles of
// pll_lock high and drops it on the first cycle pll_lock is low.
module pclk_lock_qual #(
    parameter int LOCK_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_hit,
    output logic locked
);

    localparam int CW = $clog2(LOCK_CYC + 1);

    logic [CW-1:0] count;

    // lock_hit marks the single edge on which lock becomes qualified.
    assign lock_hit = pll_lock && (count == CW'(LOCK_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            locked <= 1'b0;
        end else if (!pll_lock) begin
            count  <= '0;
            locked <= 1'b0;
        end else begin
            if (count != CW'(LOCK_CYC))
                count <= count + 1'b1;
            if (lock_hit)
                locked <= 1'b1;
        end
    end

endmodule

// File: rtl/pclk_rate_ctrl.sv
// PHY common-clock sequencer: qualifies PLL lock, then gates PCLK, resets the
// divider and loads a new ratio whenever the MAC changes DataBusWidth.
module pclk_rate_ctrl
    import pclk_rate_pkg::*;
#(
    parameter int LOCK_CYC    = 16,
    parameter int GATE_CYC    = 4,
    parameter int DIV_RST_CYC = 2,
    parameter int SETTLE_CYC  = 4
) (
    input  logic       Ref_Clk,
    input  logic       Rst_n,
    input  logic       Pll_Lock,
    input  logic [5:0] Width_Req,
    input  logic       Width_Req_Valid,
    output logic       Width_Req_Ready,
    output logic [7:0] Div_Ratio,
    output logic       Div_Rst_n,
    output logic       Pclk_En,
    output logic [5:0] Active_Width,
    output logic       Rate_Done,
    output logic       Width_Err,
    output logic       Locked
);

    localparam int MAX_A   = (GATE_CYC > DIV_RST_CYC) ? GATE_CYC : DIV_RST_CYC;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] phase_cnt;
    logic          phase_last;
    logic          count_en;
    logic [5:0]    pend_width;
    logic [7:0]    pend_ratio;
    logic          from_lock;
    logic          lock_hit;
    logic          accept;
    logic          start_change;
    logic          same_width;
    logic          bad_width;
    ratio_lookup_t req_lookup;

    pclk_lock_qual #(
        .LOCK_CYC (LOCK_CYC)
    ) u_lock_qual (
        .clk      (Ref_Clk),
        .rst_n    (Rst_n),
        .pll_lock (Pll_Lock),
        .lock_hit (lock_hit),
        .locked   (Locked)
    );

    assign req_lookup = width_to_ratio(Width_Req);

    // Lock loss outranks a request presented in the same cycle.
    assign accept       = (state == ST_RUN) && Width_Req_Valid && Pll_Lock;
    assign start_change = accept && req_lookup.valid && (Width_Req != Active_Width);
    assign same_width   = accept && req_lookup.valid && (Width_Req == Active_Width);
    assign bad_width    = accept && !req_lookup.valid;

    always_comb begin
        count_en   = 1'b1;
        phase_last = 1'b0;
        case (state)
            ST_GATE:    phase_last = (phase_cnt == CW'(GATE_CYC - 1));
            ST_DIV_RST: phase_last = (phase_cnt == CW'(DIV_RST_CYC - 1));
            ST_SETTLE:  phase_last = (phase_cnt == CW'(SETTLE_CYC - 1));
            default:    count_en   = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_LOCK: if (lock_hit)     state_nxt = ST_SETTLE;
            ST_RUN:       if (start_change) state_nxt = ST_GATE;
            ST_GATE:      if (phase_last)   state_nxt = ST_DIV_RST;
            ST_DIV_RST:   if (phase_last)   state_nxt = ST_SETTLE;
            ST_SETTLE:    if (phase_last)   state_nxt = ST_RUN;
            default:                        state_nxt = ST_WAIT_LOCK;
        endcase
        if (state != ST_WAIT_LOCK && !Pll_Lock)
            state_nxt = ST_WAIT_LOCK;
    end

    // Outputs are registered from the next state so they change cleanly on
    // the same edge as the state they describe.
    always_ff @(posedge Ref_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state           <= ST_WAIT_LOCK;
            phase_cnt       <= '0;
            pend_width      <= W8;
            pend_ratio      <= R10;
            from_lock       <= 1'b0;
            Width_Req_Ready <= 1'b0;
            Div_Ratio       <= R10;
            Div_Rst_n       <= 1'b0;
            Pclk_En         <= 1'b0;
            Active_Width    <= W8;
            Rate_Done       <= 1'b0;
            Width_Err       <= 1'b0;
        end else begin
            state           <= state_nxt;
            phase_cnt       <= (state_nxt != state || !count_en) ? '0 : phase_cnt + 1'b1;
            Width_Req_Ready <= (state_nxt == ST_RUN);
            Pclk_En         <= (state_nxt == ST_RUN);
            Div_Rst_n       <= (state_nxt == ST_RUN) || (state_nxt == ST_GATE) ||
                               (state_nxt == ST_SETTLE);
            Rate_Done       <= same_width ||
                               (state == ST_SETTLE && state_nxt == ST_RUN && !from_lock);
            Width_Err       <= bad_width;

            if (state == ST_WAIT_LOCK && state_nxt == ST_SETTLE)
                from_lock <= 1'b1;
            else if (start_change)
                from_lock <= 1'b0;

            if (start_change) begin
                pend_width <= Width_Req;
                pend_ratio <= req_lookup.ratio;
            end

            if (state == ST_GATE && state_nxt == ST_DIV_RST) begin
                Div_Ratio    <= pend_ratio;
                Active_Width <= pend_width;
            end
        end
    end

endmodule

// File: tb/tb_pclk_rate_ctrl.sv
// Self-checking bench for pclk_rate_ctrl: an elapsed-time model of the rate
// change sequence is compared with the DUT every cycle, plus literal pins.
module tb_pclk_rate_ctrl;

    localparam int LOCK_N   = 16;
    localparam int GATE_N   = 4;
    localparam int DIVRST_N = 2;
    localparam int SETTLE_N = 4;
    localparam int CHANGE_N = GATE_N + DIVRST_N + SETTLE_N;

    logic       Ref_Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic       Pll_Lock = 1'b0;
    logic [5:0] Width_Req = 6'd8;
    logic       Width_Req_Valid = 1'b0;
    logic       Width_Req_Ready;
    logic [7:0] Div_Ratio;
    logic       Div_Rst_n;
    logic       Pclk_En;
    logic [5:0] Active_Width;
    logic       Rate_Done;
    logic       Width_Err;
    logic       Locked;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    pclk_rate_ctrl #(
        .LOCK_CYC    (LOCK_N),
        .GATE_CYC    (GATE_N),
        .DIV_RST_CYC (DIVRST_N),
        .SETTLE_CYC  (SETTLE_N)
    ) dut (
        .Ref_Clk         (Ref_Clk),
        .Rst_n           (Rst_n),
        .Pll_Lock        (Pll_Lock),
        .Width_Req       (Width_Req),
        .Width_Req_Valid (Width_Req_Valid),
        .Width_Req_Ready (Width_Req_Ready),
        .Div_Ratio       (Div_Ratio),
        .Div_Rst_n       (Div_Rst_n),
        .Pclk_En         (Pclk_En),
        .Active_Width    (Active_Width),
        .Rate_Done       (Rate_Done),
        .Width_Err       (Width_Err),
        .Locked          (Locked)
    );

    always #5 Ref_Clk = ~Ref_Clk;

    always @(posedge Ref_Clk) cycle++;

    // Model: lock is a run of consecutive high cycles; a change is a count of
    // cycles elapsed since acceptance (1..CHANGE_N), start-up enters at the
    // settle phase. Commit happens when elapsed reaches GATE_N+1.
    bit       mLocked;
    int       mLockRun;
    bit       mBusy;
    bit       mStartup;
    int       mElapsed;
    int       mPendWidth;
    int       mActive;
    int       mRatio;
    bit       mRateDone;
    bit       mWidthErr;

    function automatic bit legalWidth(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    function automatic int ratioOf(input int w);
        return (w * 10) / 8;
    endfunction

    task automatic modelReset();
        mLocked   = 0;
        mLockRun  = 0;
        mBusy     = 0;
        mStartup  = 0;
        mElapsed  = 0;
        mActive   = 8;
        mRatio    = 10;
        mRateDone = 0;
        mWidthErr = 0;
    endtask

    task automatic modelStep();
        mRateDone = 0;
        mWidthErr = 0;
        if (!mLocked) begin
            mLockRun = Pll_Lock ? mLockRun + 1 : 0;
            if (mLockRun == LOCK_N) begin
                mLocked  = 1;
                mBusy    = 1;
                mStartup = 1;
                mElapsed = GATE_N + DIVRST_N + 1;
            end
        end else if (!Pll_Lock) begin
            mLocked  = 0;
            mLockRun = 0;
            mBusy    = 0;
        end else if (mBusy) begin
            mElapsed++;
            if (mElapsed == GATE_N + 1) begin
                mActive = mPendWidth;
                mRatio  = ratioOf(mPendWidth);
            end
            if (mElapsed == CHANGE_N + 1) begin
                mBusy     = 0;
                mRateDone = !mStartup;
            end
        end else if (Width_Req_Valid) begin
            if (!legalWidth(int'(Width_Req)))
                mWidthErr = 1;
            else if (int'(Width_Req) == mActive)
                mRateDone = 1;
            else begin
                mBusy      = 1;
                mStartup   = 0;
                mElapsed   = 1;
                mPendWidth = int'(Width_Req);
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge Ref_Clk or negedge Rst_n);
            if (!Rst_n) modelReset();
            else        modelStep();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Ref_Clk) begin
        bit       expRun;
        bit       expDivRst;
        expRun    = mLocked && !mBusy;
        expDivRst = mLocked && !(mBusy && mElapsed >= GATE_N + 1 && mElapsed <= GATE_N + DIVRST_N);
        testsRun++;
        if (Width_Req_Ready !== expRun || Pclk_En !== expRun || Div_Rst_n !== expDivRst ||
            Div_Ratio !== 8'(mRatio) || Active_Width !== 6'(mActive) ||
            Rate_Done !== mRateDone || Width_Err !== mWidthErr || Locked !== mLocked) begin
            testsFailed++;
            $display("[TB] FAIL model_compare cycle %0d: actual rdy=%b pen=%b drn=%b ratio=%0d aw=%0d done=%b err=%b lck=%b required rdy=%b pen=%b drn=%b ratio=%0d aw=%0d done=%b err=%b lck=%b",
                     cycle, Width_Req_Ready, Pclk_En, Div_Rst_n, Div_Ratio, Active_Width,
                     Rate_Done, Width_Err, Locked, expRun, expRun, expDivRst, mRatio,
                     mActive, mRateDone, mWidthErr, mLocked);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        testsRun++;
        if (actual != required) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ratio"}, int'(Div_Ratio), 10);
        checkOutput({tag, "_width"}, int'(Active_Width), 8);
        checkOutput({tag, "_div_rst_n"}, int'(Div_Rst_n), 0);
        checkOutput({tag, "_pclk_en"}, int'(Pclk_En), 0);
        checkOutput({tag, "_ready"}, int'(Width_Req_Ready), 0);
        checkOutput({tag, "_rate_done"}, int'(Rate_Done), 0);
        checkOutput({tag, "_width_err"}, int'(Width_Err), 0);
        checkOutput({tag, "_locked"}, int'(Locked), 0);
    endtask

    // Presents one request for a single edge; returns at the negedge after
    // acceptance (first cycle of the response).
    task automatic applyStimulus(input logic [5:0] width);
        Width_Req       = width;
        Width_Req_Valid = 1'b1;
        @(negedge Ref_Clk);
        Width_Req_Valid = 1'b0;
    endtask

    task automatic waitForPclk(input string name, input int required);
        int n;
        n = 0;
        while (!Pclk_En && n < 80) begin
            @(negedge Ref_Clk);
            n++;
        end
        checkOutput(name, n, required);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, actual running, required finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Pll_Lock = 1'b1;
        #1 Rst_n = 1'b0;
        repeat (3) @(negedge Ref_Clk);
        checkResetValues("reset");
        Rst_n = 1'b1;

        // Start-up: lock after 16 cycles, PCLK after 4 more, no Rate_Done.
        repeat (LOCK_N - 1) @(negedge Ref_Clk);
        checkOutput("locked_early", int'(Locked), 0);
        @(negedge Ref_Clk);
        checkOutput("locked_at_16", int'(Locked), 1);
        checkOutput("div_rst_n_at_lock", int'(Div_Rst_n), 1);
        checkOutput("pclk_en_settling", int'(Pclk_En), 0);
        repeat (SETTLE_N) @(negedge Ref_Clk);
        checkOutput("pclk_en_startup", int'(Pclk_En), 1);
        checkOutput("startup_no_done", int'(Rate_Done), 0);
        checkOutput("startup_ratio", int'(Div_Ratio), 10);

        // Same width: immediate Rate_Done, no gating.
        applyStimulus(6'd8);
        checkOutput("same_width_done", int'(Rate_Done), 1);
        checkOutput("same_width_pclk", int'(Pclk_En), 1);
        @(negedge Ref_Clk);
        checkOutput("same_width_done_end", int'(Rate_Done), 0);

        // Illegal width.
        applyStimulus(6'd12);
        checkOutput("illegal_err", int'(Width_Err), 1);
        checkOutput("illegal_ready", int'(Width_Req_Ready), 1);
        checkOutput("illegal_ratio", int'(Div_Ratio), 10);
        checkOutput("illegal_width", int'(Active_Width), 8);
        @(negedge Ref_Clk);
        checkOutput("illegal_err_end", int'(Width_Err), 0);

        // Lock loss during GATE drops the pending change.
        applyStimulus(6'd16);
        checkOutput("gate_pclk_off", int'(Pclk_En), 0);
        Pll_Lock = 1'b0;
        @(negedge Ref_Clk);
        checkOutput("lockloss_locked", int'(Locked), 0);
        checkOutput("lockloss_div_rst_n", int'(Div_Rst_n), 0);
        checkOutput("lockloss_ratio", int'(Div_Ratio), 10);
        repeat (2) @(negedge Ref_Clk);
        Pll_Lock = 1'b1;
        waitForPclk("relock_cycles", LOCK_N + SETTLE_N);
        checkOutput("relock_width", int'(Active_Width), 8);
        checkOutput("relock_no_done", int'(Rate_Done), 0);

        // Full change to 32.
        applyStimulus(6'd32);
        checkOutput("chg_pclk_off", int'(Pclk_En), 0);
        repeat (GATE_N - 1) @(negedge Ref_Clk);
        checkOutput("chg_ratio_before", int'(Div_Ratio), 10);
        @(negedge Ref_Clk);
        checkOutput("chg_ratio_40", int'(Div_Ratio), 40);
        checkOutput("chg_width_32", int'(Active_Width), 32);
        checkOutput("chg_div_rst_lo1", int'(Div_Rst_n), 0);
        @(negedge Ref_Clk);
        checkOutput("chg_div_rst_lo2", int'(Div_Rst_n), 0);
        @(negedge Ref_Clk);
        checkOutput("chg_div_rst_hi", int'(Div_Rst_n), 1);
        repeat (SETTLE_N - 1) @(negedge Ref_Clk);
        checkOutput("chg_pclk_still_off", int'(Pclk_En), 0);
        @(negedge Ref_Clk);
        checkOutput("chg_pclk_on", int'(Pclk_En), 1);
        checkOutput("chg_done", int'(Rate_Done), 1);
        @(negedge Ref_Clk);
        checkOutput("chg_done_end", int'(Rate_Done), 0);

        // Reset asserted in the middle of DIV_RST.
        applyStimulus(6'd16);
        repeat (GATE_N) @(negedge Ref_Clk);
        checkOutput("divrst_ratio_20", int'(Div_Ratio), 20);
        checkOutput("divrst_low", int'(Div_Rst_n), 0);
        @(posedge Ref_Clk);
        #2 Rst_n = 1'b0;
        #1 checkResetValues("async_reset");
        repeat (2) @(negedge Ref_Clk);
        Rst_n = 1'b1;
        waitForPclk("post_reset_cycles", LOCK_N + SETTLE_N);
        checkOutput("post_reset_width", int'(Active_Width), 8);

        repeat (3) @(negedge Ref_Clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
